plic_bram_arbiter: RTL and testbench

Round-robin arbiter sharing the PLIC's single BRAM-style register port (word address, 32-bit data, byte write mask, one-cycle read latency) among several requesters. Typical requesters are the TileLink BRAM bridge and a boot-time configuration sequencer that programs priorities and enables. The block issues at most one access per cycle and routes each response back to its issuer with a valid/ready handshake. Response back-pressure is absorbed by a one-entry hold register.

---
 rtl/plic_bram_arbiter_if.sv | 43 ++++
 rtl/plic_bram_arbiter.sv | 128 ++++++++++++
 tb/tb_plic_bram_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/plic_bram_arbiter_if.sv
// Requester-side request/response handshakes plus the shared BRAM register port
// of the PLIC arbiter, bundled so the arbiter and its environment share one definition.
interface plic_bram_arbiter_if #(
    parameter int NumReq    = 2,
    parameter int AddrWidth = 20,
    parameter int DataWidth = 32
);
    localparam int MaskWidth = DataWidth / 8;

    logic [NumReq-1:0]           req_valid_i;
    logic [NumReq-1:0]           req_ready_o;
    logic [NumReq-1:0]           req_we_i;
    logic [NumReq*MaskWidth-1:0] req_wmask_i;
    logic [NumReq*AddrWidth-1:0] req_addr_i;
    logic [NumReq*DataWidth-1:0] req_wdata_i;

    logic [NumReq-1:0]           rsp_valid_o;
    logic [NumReq-1:0]           rsp_ready_i;
    logic [DataWidth-1:0]        rsp_rdata_o;

    logic                        bram_en_o;
    logic                        bram_we_o;
    logic [MaskWidth-1:0]        bram_wmask_o;
    logic [AddrWidth-1:0]        bram_addr_o;
    logic [DataWidth-1:0]        bram_wdata_o;
    logic [DataWidth-1:0]        bram_rdata_i;

    // The arbiter side
    modport slave (
        input  req_valid_i, req_we_i, req_wmask_i, req_addr_i, req_wdata_i,
        input  rsp_ready_i, bram_rdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o,
        output bram_en_o, bram_we_o, bram_wmask_o, bram_addr_o, bram_wdata_o
    );

    // The requesters together with the BRAM itself
    modport master (
        output req_valid_i, req_we_i, req_wmask_i, req_addr_i, req_wdata_i,
        output rsp_ready_i, bram_rdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o,
        input  bram_en_o, bram_we_o, bram_wmask_o, bram_addr_o, bram_wdata_o
    );
endinterface

// File: rtl/plic_bram_arbiter.sv
// Round-robin arbiter sharing the PLIC's one-cycle-latency BRAM register port among
// NumReq requesters; one access outstanding at a time, stalled read data kept in a hold register.
module plic_bram_arbiter #(
    parameter int NumReq    = 2,
    parameter int AddrWidth = 20,
    parameter int DataWidth = 32
) (
    input logic                clk_i,
    input logic                rst_ni,
    plic_bram_arbiter_if.slave bus
);
    localparam int PtrWidth  = $clog2(NumReq);
    localparam int MaskWidth = DataWidth / 8;

    typedef enum logic [1:0] {StIdle, StLive, StHeld} rspState_e;

    rspState_e             state_q, state_d;
    logic [PtrWidth-1:0]   ptr_q, ptr_d;
    logic [PtrWidth-1:0]   owner_q, owner_d;
    logic                  wasWrite_q, wasWrite_d;
    logic [DataWidth-1:0]  hold_q, hold_d;

    logic                  rspAccept;
    logic                  canIssue;
    logic                  grantValid;
    logic [PtrWidth-1:0]   grantIdx;
    logic [PtrWidth:0]     candIdx;
    logic [DataWidth-1:0]  liveData;

    assign rspAccept = (state_q != StIdle) && bus.rsp_ready_i[owner_q];
    assign canIssue  = rst_ni && ((state_q == StIdle) || rspAccept);
    assign liveData  = wasWrite_q ? '0 : bus.bram_rdata_i;

    // Search starts at ptr and wraps by explicit compare so non-power-of-two NumReq works
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = '0;
        candIdx    = '0;
        for (int k = 0; k < NumReq; k++) begin
            candIdx = {1'b0, ptr_q} + (PtrWidth+1)'(k);
            if (candIdx >= (PtrWidth+1)'(NumReq)) begin
                candIdx = candIdx - (PtrWidth+1)'(NumReq);
            end
            if (canIssue && !grantValid && bus.req_valid_i[candIdx[PtrWidth-1:0]]) begin
                grantValid = 1'b1;
                grantIdx   = candIdx[PtrWidth-1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            owner_q    <= '0;
            wasWrite_q <= 1'b0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            wasWrite_q <= wasWrite_d;
            hold_q     <= hold_d;
        end
    end

    // A new issue always restarts the response in LIVE, even out of a just-accepted HELD
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        wasWrite_d = wasWrite_q;
        hold_d     = hold_q;
        if (grantValid) begin
            state_d    = StLive;
            owner_d    = grantIdx;
            wasWrite_d = bus.req_we_i[grantIdx];
            ptr_d      = (grantIdx == PtrWidth'(NumReq - 1)) ? '0 : grantIdx + 1'b1;
        end else begin
            case (state_q)
                StLive: begin
                    if (rspAccept) begin
                        state_d = StIdle;
                    end else begin
                        hold_d  = liveData;
                        state_d = StHeld;
                    end
                end
                StHeld: begin
                    if (rspAccept) begin
                        state_d = StIdle;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.req_ready_o  = '0;
        bus.bram_en_o    = 1'b0;
        bus.bram_we_o    = 1'b0;
        bus.bram_wmask_o = '0;
        bus.bram_addr_o  = '0;
        bus.bram_wdata_o = '0;
        bus.rsp_valid_o  = '0;
        bus.rsp_rdata_o  = '0;
        if (grantValid) begin
            bus.req_ready_o[grantIdx] = 1'b1;
            bus.bram_en_o    = 1'b1;
            bus.bram_we_o    = bus.req_we_i[grantIdx];
            bus.bram_wmask_o = bus.req_wmask_i[int'(grantIdx) * MaskWidth +: MaskWidth];
            bus.bram_addr_o  = bus.req_addr_i[int'(grantIdx) * AddrWidth +: AddrWidth];
            bus.bram_wdata_o = bus.req_wdata_i[int'(grantIdx) * DataWidth +: DataWidth];
        end
        case (state_q)
            StLive: begin
                bus.rsp_valid_o[owner_q] = 1'b1;
                bus.rsp_rdata_o          = liveData;
            end
            StHeld: begin
                bus.rsp_valid_o[owner_q] = 1'b1;
                bus.rsp_rdata_o          = hold_q;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_plic_bram_arbiter.sv
// Randomized bench for plic_bram_arbiter: requesters and BRAM are modelled here, and a
// transaction-level reference predicts grants, BRAM strobes and responses every cycle.
module tb_plic_bram_arbiter;
    localparam int NumReq    = 2;
    localparam int AddrWidth = 20;
    localparam int DataWidth = 32;
    localparam int MaskWidth = DataWidth / 8;

    logic clk = 1'b0;
    logic rstN;

    always #5 clk = ~clk;

    plic_bram_arbiter_if #(.NumReq(NumReq), .AddrWidth(AddrWidth), .DataWidth(DataWidth)) bus ();

    plic_bram_arbiter #(.NumReq(NumReq), .AddrWidth(AddrWidth), .DataWidth(DataWidth)) dut (
        .clk_i  (clk),
        .rst_ni (rstN),
        .bus    (bus.slave)
    );

    int compared   = 0;
    int mismatched = 0;

    logic [AddrWidth-1:0] addrTable [16];
    logic [DataWidth-1:0] bramMem [logic [AddrWidth-1:0]];
    logic [DataWidth-1:0] expMem  [logic [AddrWidth-1:0]];

    logic                 reqValid [NumReq];
    logic                 reqWe    [NumReq];
    logic [MaskWidth-1:0] reqMask  [NumReq];
    logic [AddrWidth-1:0] reqAddr  [NumReq];
    logic [DataWidth-1:0] reqData  [NumReq];
    logic                 rspReady [NumReq];

    bit                   outstanding;
    int                   outOwner;
    logic [DataWidth-1:0] outData;
    int                   rrPtr;

    bit                   lastRd;
    logic [AddrWidth-1:0] lastAddr;

    int reqProb, readyProb, rstProb;

    int pCycles [5] = '{4, 40, 300, 400, 300};
    int pReq    [5] = '{100, 100, 60, 80, 20};
    int pReady  [5] = '{100, 100, 30, 70, 70};
    int pRst    [5] = '{100, 0, 0, 3, 0};

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DataWidth-1:0] memRead(input logic [AddrWidth-1:0] a);
        if (bramMem.exists(a)) return bramMem[a];
        return $urandom;
    endfunction

    function automatic logic [DataWidth-1:0] mergeBytes(input logic [DataWidth-1:0] old,
                                                        input logic [DataWidth-1:0] data,
                                                        input logic [MaskWidth-1:0] mask);
        logic [DataWidth-1:0] res;
        res = old;
        for (int b = 0; b < MaskWidth; b++) begin
            if (mask[b]) res[8*b +: 8] = data[8*b +: 8];
        end
        return res;
    endfunction

    // Requesters keep a pending request stable until granted; BRAM answers the previous read
    task automatic applyStimulus();
        rstN = ($urandom_range(99) < rstProb) ? 1'b0 : 1'b1;
        for (int i = 0; i < NumReq; i++) begin
            if (!reqValid[i] && ($urandom_range(99) < reqProb)) begin
                reqValid[i] = 1'b1;
                reqWe[i]    = 1'($urandom_range(1));
                reqMask[i]  = MaskWidth'($urandom_range(15));
                reqAddr[i]  = addrTable[$urandom_range(15)];
                reqData[i]  = $urandom;
            end
            rspReady[i] = ($urandom_range(99) < readyProb);
            bus.req_valid_i[i]                          = reqValid[i];
            bus.req_we_i[i]                             = reqWe[i];
            bus.req_wmask_i[i*MaskWidth +: MaskWidth]   = reqMask[i];
            bus.req_addr_i[i*AddrWidth +: AddrWidth]    = reqAddr[i];
            bus.req_wdata_i[i*DataWidth +: DataWidth]   = reqData[i];
            bus.rsp_ready_i[i]                          = rspReady[i];
        end
        bus.bram_rdata_i = lastRd ? memRead(lastAddr) : $urandom;
    endtask

    task automatic checkCycle();
        int g;
        bit canIssue;
        logic                 expWe;
        logic [MaskWidth-1:0] expMask;
        logic [AddrWidth-1:0] expAddr;
        logic [DataWidth-1:0] expWdata;
        g = -1;
        canIssue = rstN && (!outstanding || rspReady[outOwner]);
        if (canIssue) begin
            for (int k = 0; k < NumReq; k++) begin
                int idx;
                idx = (rrPtr + k) % NumReq;
                if (g < 0 && reqValid[idx]) g = idx;
            end
        end
        expWe = 1'b0; expMask = '0; expAddr = '0; expWdata = '0;
        if (g >= 0) begin
            expWe = reqWe[g]; expMask = reqMask[g]; expAddr = reqAddr[g]; expWdata = reqData[g];
        end
        checkOutput("req_ready", 64'(bus.req_ready_o), (g >= 0) ? (64'(1) << g) : 64'(0));
        checkOutput("bram_en", 64'(bus.bram_en_o), 64'(g >= 0));
        checkOutput("bram_we", 64'(bus.bram_we_o), 64'(expWe));
        checkOutput("bram_wmask", 64'(bus.bram_wmask_o), 64'(expMask));
        checkOutput("bram_addr", 64'(bus.bram_addr_o), 64'(expAddr));
        checkOutput("bram_wdata", 64'(bus.bram_wdata_o), 64'(expWdata));
        checkOutput("rsp_valid", 64'(bus.rsp_valid_o), outstanding ? (64'(1) << outOwner) : 64'(0));
        checkOutput("rsp_rdata", 64'(bus.rsp_rdata_o), outstanding ? 64'(outData) : 64'(0));

        lastRd   = bus.bram_en_o && !bus.bram_we_o;
        lastAddr = bus.bram_addr_o;
        if (bus.bram_en_o && bus.bram_we_o) begin
            bramMem[bus.bram_addr_o] = mergeBytes(memRead(bus.bram_addr_o), bus.bram_wdata_o,
                                                  bus.bram_wmask_o);
        end

        if (!rstN) begin
            outstanding = 1'b0;
            rrPtr       = 0;
        end else if (g >= 0) begin
            outstanding = 1'b1;
            outOwner    = g;
            outData     = reqWe[g] ? '0 : expMem[reqAddr[g]];
            if (reqWe[g]) expMem[reqAddr[g]] = mergeBytes(expMem[reqAddr[g]], reqData[g], reqMask[g]);
            rrPtr       = (g + 1) % NumReq;
            reqValid[g] = 1'b0;
        end else if (outstanding && rspReady[outOwner]) begin
            outstanding = 1'b0;
        end
    endtask

    initial begin
        addrTable = '{20'h00400, 20'h00001, 20'h02000, 20'h00000, 20'h00002, 20'h00003,
                      20'h00010, 20'h00011, 20'h00100, 20'h00101, 20'h01000, 20'h01001,
                      20'h0FFFF, 20'h10000, 20'hFFFFF, 20'h80000};
        for (int i = 0; i < 16; i++) begin
            bramMem[addrTable[i]] = $urandom;
        end
        bramMem[20'h00400] = 32'hDEADBEEF;
        bramMem[20'h00001] = 32'h00000005;
        for (int i = 0; i < 16; i++) begin
            expMem[addrTable[i]] = bramMem[addrTable[i]];
        end
        for (int i = 0; i < NumReq; i++) begin
            reqValid[i] = 1'b0; reqWe[i] = 1'b0; reqMask[i] = '0;
            reqAddr[i] = '0; reqData[i] = '0; rspReady[i] = 1'b0;
        end
        outstanding = 1'b0; outOwner = 0; outData = '0; rrPtr = 0;
        lastRd = 1'b0; lastAddr = '0;
        rstN = 1'b0;
        bus.req_valid_i = '0; bus.req_we_i = '0; bus.req_wmask_i = '0;
        bus.req_addr_i = '0; bus.req_wdata_i = '0; bus.rsp_ready_i = '0;
        bus.bram_rdata_i = '0;
        repeat (2) @(posedge clk);

        for (int p = 0; p < 5; p++) begin
            reqProb   = pReq[p];
            readyProb = pReady[p];
            rstProb   = pRst[p];
            for (int c = 0; c < pCycles[p]; c++) begin
                @(posedge clk);
                #1;
                applyStimulus();
                @(negedge clk);
                checkCycle();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
